// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stage
// Brief    : Load/store unit pipeline stage. Passes ALU results through,
//            rejects misaligned accesses, and runs one data-bus transaction
//            per aligned load/store with byte-lane alignment and extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mem_op,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_wen,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic            out_reg_wen,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_misalign,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_we,
    output logic [XLEN-1:0] req_addr,
    output logic [XLEN-1:0] req_wdata,
    output logic [7:0]      req_wmask,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_rdata
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    logic [1:0]      r_state;
    logic            r_is_store;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic            r_reg_wen;

    logic            r_out_valid;
    logic            r_out_misalign;
    logic [4:0]      r_out_rd;
    logic            r_out_reg_wen;
    logic [XLEN-1:0] r_out_wdata;

    logic            w_is_mem;
    logic            w_aligned;
    logic [7:0]      w_size_mask;
    logic [XLEN-1:0] w_rdata_shift;
    logic [XLEN-1:0] w_load_data;

    // Reserved op code 11 behaves like a plain ALU instruction
    assign w_is_mem = (in_mem_op == 2'b01) || (in_mem_op == 2'b10);

    // Natural alignment check of the incoming address against access size
    always_comb begin
        w_aligned = 1'b1;
        case (in_size)
            2'b01:   w_aligned = (in_addr[0] == 1'b0);
            2'b10:   w_aligned = (in_addr[1:0] == 2'b00);
            2'b11:   w_aligned = (in_addr[2:0] == 3'b000);
            default: w_aligned = 1'b1;
        endcase
    end

    // Unshifted byte-enable pattern for the latched access size
    always_comb begin
        case (r_size)
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // Align returned data to bit 0, then truncate and sign/zero-extend
    assign w_rdata_shift = resp_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_load_data = w_rdata_shift;
        case (r_size)
            2'b00:   w_load_data = {{(XLEN-8){~r_unsigned & w_rdata_shift[7]}},
                                    w_rdata_shift[7:0]};
            2'b01:   w_load_data = {{(XLEN-16){~r_unsigned & w_rdata_shift[15]}},
                                    w_rdata_shift[15:0]};
            2'b10:   w_load_data = {{(XLEN-32){~r_unsigned & w_rdata_shift[31]}},
                                    w_rdata_shift[31:0]};
            default: w_load_data = w_rdata_shift;
        endcase
    end

    // Request payload is driven straight from the latched instruction, so it
    // stays stable for as long as the bus holds off req_ready
    assign req_valid = (r_state == c_st_req);
    assign req_we    = r_is_store;
    assign req_addr  = {r_addr[XLEN-1:3], 3'b000};
    assign req_wmask = r_is_store ? (w_size_mask << r_addr[2:0]) : 8'h00;
    assign req_wdata = r_wdata << {r_addr[2:0], 3'b000};

    assign in_ready  = (r_state == c_st_idle) && !rst;

    assign out_valid    = r_out_valid;
    assign out_misalign = r_out_misalign;
    assign out_rd       = r_out_rd;
    assign out_reg_wen  = r_out_reg_wen;
    assign out_wdata    = r_out_wdata;

    // Stage FSM, payload latch and single-cycle result pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_is_store     <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rd           <= 5'd0;
            r_reg_wen      <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_misalign <= 1'b0;
            r_out_rd       <= 5'd0;
            r_out_reg_wen  <= 1'b0;
            r_out_wdata    <= '0;
        end else begin
            r_out_valid    <= 1'b0;
            r_out_misalign <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        if (w_is_mem && !w_aligned) begin
                            r_out_valid    <= 1'b1;
                            r_out_misalign <= 1'b1;
                            r_out_rd       <= in_rd;
                            r_out_reg_wen  <= 1'b0;
                            r_out_wdata    <= '0;
                        end else if (w_is_mem) begin
                            r_is_store <= (in_mem_op == 2'b10);
                            r_size     <= in_size;
                            r_unsigned <= in_unsigned;
                            r_addr     <= in_addr;
                            r_wdata    <= in_wdata;
                            r_rd       <= in_rd;
                            r_reg_wen  <= in_reg_wen;
                            r_state    <= c_st_req;
                        end else begin
                            r_out_valid   <= 1'b1;
                            r_out_rd      <= in_rd;
                            r_out_reg_wen <= in_reg_wen && (in_rd != 5'd0);
                            r_out_wdata   <= in_addr;
                        end
                    end
                end
                c_st_req: begin
                    if (req_ready) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (resp_valid) begin
                        r_out_valid   <= 1'b1;
                        r_out_rd      <= r_rd;
                        r_out_reg_wen <= !r_is_store && r_reg_wen && (r_rd != 5'd0);
                        r_out_wdata   <= r_is_store ? '0 : w_load_data;
                        r_state       <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
